// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state codes, line idle level, parity helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: IDLE/START/DATA/PARITY/STOP state encodings, LINE_IDLE, MAX_DATA_W, even_parity().
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] START  = 3'b001;
  localparam logic [2:0] DATA   = 3'b010;
  localparam logic [2:0] PARITY = 3'b011;
  localparam logic [2:0] STOP   = 3'b100;

  // Level the serial line rests at between frames.
  localparam logic LINE_IDLE = 1'b1;

  // Widest data word a frame may carry; callers zero-extend into this width.
  localparam int MAX_DATA_W = 16;

  // Even parity: the returned bit makes the total count of ones (data + parity) even.
  // Zero-extension does not change the result.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_tick on the last clk cycle of every CLKS_PER_BIT-cycle bit slot.
// Latency: first tick CLKS_PER_BIT cycles after restart; then one tick every CLKS_PER_BIT cycles.
// Backpressure: none; free-running, realigned by restart.
// Ports: clk, rst (sync, active high), restart (realign to a new bit slot), bit_tick (combinational from the counter).
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // At CLKS_PER_BIT=1 the counter is pinned at 0 and every cycle is a tick.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_master.sv
// UART transmitter: serialises one word per valid/ready handshake as start, LSB-first data, [even parity], stop bit(s).
// Latency: start bit on u_tx right after the handshake edge; u_tx_done pulses F*CLKS_PER_BIT edges after the handshake.
// Backpressure: tx_ready is high only in IDLE; tx_valid without tx_ready is ignored and the bus must hold its data.
// Ports: clk, rst (sync, active high), tx_data/tx_valid/tx_ready (bus side),
//        u_tx (serial line, idle high), busy (frame in flight), u_tx_done (one-cycle end-of-frame pulse).
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_master
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              u_tx,
  output logic              busy,
  output logic              u_tx_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [IW-1:0]     bit_idx;
  logic              stop_idx;
  logic              bit_tick;
  logic              hs;
`ifdef UART_TX_PARITY_EN
  logic              par_bit;
`endif

  assign hs = tx_valid && tx_ready;

  // The data bit due next sits at bit 0 of the shifted register, so the
  // line value is registered together with the state change.
  assign shreg_nxt = shreg >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (hs),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      u_tx      <= LINE_IDLE;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      u_tx_done <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      u_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          u_tx     <= LINE_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          if (hs) begin
            shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_bit  <= even_parity(MAX_DATA_W'(tx_data));
`endif
            state    <= START;
            u_tx     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            state   <= DATA;
            u_tx    <= shreg[0];
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              u_tx     <= par_bit;
`else
              state    <= STOP;
              u_tx     <= LINE_IDLE;
              stop_idx <= 1'b0;
`endif
            end else begin
              // bit_idx stops at LAST_IDX; it is only advanced below it.
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg_nxt;
              u_tx    <= shreg_nxt[0];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state    <= STOP;
            u_tx     <= LINE_IDLE;
            stop_idx <= 1'b0;
          end
        end
`endif

        STOP: begin
          if (bit_tick) begin
            if (stop_idx == LAST_STOP) begin
              state     <= IDLE;
              u_tx      <= LINE_IDLE;
              busy      <= 1'b0;
              tx_ready  <= 1'b1;
              u_tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        // Unused encodings (and PARITY when compiled out) fall back to a safe idle line.
        default: begin
          state    <= IDLE;
          u_tx     <= LINE_IDLE;
          tx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_master.sv
module tb_uart_master;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = 1 + 8 + P + 1;   // bits per frame, one stop bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy, a_done;
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, b_done;

  int tests = 0;
  int fails = 0;

  uart_master #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .u_tx(a_tx), .busy(a_busy), .u_tx_done(a_done)
  );

  uart_master #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .u_tx(b_tx), .busy(b_busy), .u_tx_done(b_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %s expected %s at %0t", name, got, exp, $time);
    end
  endtask

  // Reference frame: bit j of the frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < 8; i++) ones = ones ^ d[i];
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (P == 1 && j == 9) return ones;
    return 1'b1;
  endfunction

  function automatic string frame_str(input logic [7:0] d);
    string s;
    s = "";
    for (int j = 0; j < F; j++) begin
      if (frame_bit(d, j)) s = {s, "1"};
      else s = {s, "0"};
    end
    return s;
  endfunction

  // Per-cycle scoreboard: position k cycles after the accepting edge selects frame bit k/cpb.
  task automatic sb_cmp(input string tag, input logic was_rst, input logic act, input int k,
                        input int cpb, input logic [7:0] d,
                        input logic tx, input logic bsy, input logic dn, input logic rdy);
    logic etx, ebsy, edn, erdy;
    if (was_rst) begin
      etx = 1'b1; ebsy = 1'b0; edn = 1'b0; erdy = 1'b0;
    end else if (act && k < F * cpb) begin
      etx = frame_bit(d, k / cpb); ebsy = 1'b1; edn = 1'b0; erdy = 1'b0;
    end else if (act && k == F * cpb) begin
      etx = 1'b1; ebsy = 1'b0; edn = 1'b1; erdy = 1'b1;
    end else begin
      etx = 1'b1; ebsy = 1'b0; edn = 1'b0; erdy = 1'b1;
    end
    check({tag, ".u_tx"}, 32'(tx), 32'(etx));
    check({tag, ".busy"}, 32'(bsy), 32'(ebsy));
    check({tag, ".u_tx_done"}, 32'(dn), 32'(edn));
    check({tag, ".tx_ready"}, 32'(rdy), 32'(erdy));
  endtask

  logic       sa_act = 1'b0, sb_act = 1'b0;
  logic       sa_rst, sb_rst;
  int         sa_k = 0, sb_k = 0;
  logic [7:0] sa_d = 8'h00, sb_d = 8'h00;

  always @(posedge clk) begin
    sa_rst = rst;
    if (rst) sa_act = 1'b0;
    else if (a_valid && a_ready) begin sa_act = 1'b1; sa_k = 0; sa_d = a_data; end
    else if (sa_act) sa_k++;
    #1;
    sb_cmp("sb_a", sa_rst, sa_act, sa_k, 1, sa_d, a_tx, a_busy, a_done, a_ready);
    if (sa_act && sa_k == F) sa_act = 1'b0;
  end

  always @(posedge clk) begin
    sb_rst = rst;
    if (rst) sb_act = 1'b0;
    else if (b_valid && b_ready) begin sb_act = 1'b1; sb_k = 0; sb_d = b_data; end
    else if (sb_act) sb_k++;
    #1;
    sb_cmp("sb_b", sb_rst, sb_act, sb_k, 4, sb_d, b_tx, b_busy, b_done, b_ready);
    if (sb_act && sb_k == F * 4) sb_act = 1'b0;
  end

  function automatic logic tx_of(input int which);
    return (which != 0) ? b_tx : a_tx;
  endfunction
  function automatic logic rdy_of(input int which);
    return (which != 0) ? b_ready : a_ready;
  endfunction
  function automatic logic done_of(input int which);
    return (which != 0) ? b_done : a_done;
  endfunction

  task automatic drive(input int which, input logic [7:0] d, input logic v);
    if (which != 0) begin b_data = d; b_valid = v; end
    else begin a_data = d; a_valid = v; end
  endtask

  // Sends d on one instance; returns the sampled frame (one char per bit) and the done offset.
  task automatic send(input int which, input logic [7:0] d, input int pulse_at,
                      output int lat, output string seq);
    int cpb;
    int w;
    cpb = (which != 0) ? 4 : 1;
    w = 0;
    @(posedge clk); #1;
    drive(which, d, 1'b1);
    while (!rdy_of(which) && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) check("ready_wait_timeout", 32'(w), 0);
    @(posedge clk); #1;   // accepting edge; c=0 is the start bit
    drive(which, d, 1'b0);
    seq = "";
    lat = -1;
    for (int c = 0; c <= F * cpb + 2; c++) begin
      if (c % cpb == 0 && c / cpb < F) begin
        if (tx_of(which)) seq = {seq, "1"};
        else seq = {seq, "0"};
      end
      if (done_of(which) && lat < 0) lat = c;
      if (c == pulse_at) begin
        check("ignored_valid.tx_ready", 32'(rdy_of(which)), 0);
        drive(which, ~d, 1'b1);
      end
      if (c == pulse_at + 1) drive(which, d, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    string      frame;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int lat, w, dn, which, cpb, pulse;
    string seq;
    logic [7:0] d;

`ifdef UART_TX_PARITY_EN
    vecs[0].data = 8'hA5; vecs[0].frame = "01010010101";
    vecs[1].data = 8'h07; vecs[1].frame = "01110000011";
    vecs[2].data = 8'h00; vecs[2].frame = "00000000001";
    vecs[3].data = 8'hFF; vecs[3].frame = "01111111101";
`else
    vecs[0].data = 8'hA5; vecs[0].frame = "0101001011";
    vecs[1].data = 8'h07; vecs[1].frame = "0111000001";
    vecs[2].data = 8'h00; vecs[2].frame = "0000000001";
    vecs[3].data = 8'hFF; vecs[3].frame = "0111111111";
`endif

    // Reset held for three edges; the scoreboard checks the reset levels on each.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.tx_ready_held", 32'(a_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.tx_ready_release_a", 32'(a_ready), 1);
    check("rst.tx_ready_release_b", 32'(b_ready), 1);

    // Table vectors at one clock per bit.
    foreach (vecs[i]) begin
      send(0, vecs[i].data, -1, lat, seq);
      check_str($sformatf("vec%0d.frame", i), seq, vecs[i].frame);
      check($sformatf("vec%0d.done_at", i), 32'(lat), 32'(F));
    end

    // Four clocks per bit, with a valid pulse mid-frame that must be ignored.
    send(1, 8'h07, 9, lat, seq);
    check_str("cpb4.frame", seq, vecs[1].frame);
    check("cpb4.done_at", 32'(lat), 32'(F * 4));

    // Back-to-back: valid held high, data changed right after acceptance.
    @(posedge clk); #1;
    a_data = 8'h01; a_valid = 1'b1;
    w = 0;
    while (!a_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) check("b2b.ready_wait_timeout", 32'(w), 0);
    @(posedge clk); #1;
    a_data = 8'hFF;
    for (int c = 1; c <= F + 1; c++) begin
      @(posedge clk); #1;
      if (c == 5) check("b2b.ready_mid", 32'(a_ready), 0);
      if (c == F) check("b2b.done", 32'(a_done), 1);
      if (c == F + 1) begin
        check("b2b.second_start", 32'(a_tx), 0);
        check("b2b.second_busy", 32'(a_busy), 1);
        a_valid = 1'b0;
      end
    end
    repeat (F + 3) @(posedge clk);
    #1;

    // Reset during data bit 3 (a zero bit, so the return to high is visible).
    @(posedge clk); #1;
    a_data = 8'h52; a_valid = 1'b1;
    w = 0;
    while (!a_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) check("midrst.ready_wait_timeout", 32'(w), 0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst.bit3", 32'(a_tx), 0);
    check("midrst.busy", 32'(a_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.tx_high", 32'(a_tx), 1);
    check("midrst.busy_clear", 32'(a_busy), 0);
    rst = 1'b0;
    dn = 0;
    repeat (F + 4) begin
      @(posedge clk); #1;
      if (a_done) dn++;
    end
    check("midrst.no_done", 32'(dn), 0);
    send(0, 8'h52, -1, lat, seq);
    check_str("midrst.clean_frame", seq, frame_str(8'h52));
    check("midrst.clean_done_at", 32'(lat), 32'(F));

    // Random bytes on both instances, random gaps and ignored mid-frame valids.
    for (int it = 0; it < 24; it++) begin
      which = int'($urandom_range(0, 1));
      cpb = (which != 0) ? 4 : 1;
      d = 8'($urandom);
      pulse = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, F * cpb - 2)) : -1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(which, d, pulse, lat, seq);
      check_str($sformatf("rand%0d.frame", it), seq, frame_str(d));
      check($sformatf("rand%0d.done_at", it), 32'(lat), 32'(F * cpb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
